// File: rtl/uart_pkg.sv
// Shared UART definitions: stop-bit encodings, receiver FSM states and
// bit-period constants for a 50 MHz clock.
package uart_pkg;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1_5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  localparam logic [15:0] COMP_9600   = 16'd5208;
  localparam logic [15:0] COMP_19200  = 16'd2604;
  localparam logic [15:0] COMP_38400  = 16'd1302;
  localparam logic [15:0] COMP_57600  = 16'd868;
  localparam logic [15:0] COMP_115200 = 16'd434;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP1,
    RX_STOP2,
    RX_DONE
  } rx_state_t;

  // 1.5 stop bits only checks the first stop bit, so only the 2-stop codes need STOP2
  function automatic logic has_stop2(input logic [1:0] sel);
    return (sel == STOP_2) || (sel == (STOP_2 | STOP_1_5));
  endfunction

endpackage

// File: rtl/uart_receiver_sv_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module uart_sync_sv #(
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_FF-1:0] r_sync;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_sync[0] <= 1'b1;
    else        r_sync[0] <= i_d;
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_FF; gi++) begin : g_stage
      always_ff @(posedge clk or posedge resetn) begin
        if (resetn) r_sync[gi] <= 1'b1;
        else        r_sync[gi] <= r_sync[gi-1];
      end
    end
  endgenerate

  assign o_q = r_sync[SYNC_FF-1];

endmodule

// File: rtl/uart_receiver_sv.sv
// UART receiver: 8N1 with 1/1.5/2 stop bits, runtime bit period, valid/ack
// delivery with framing and sticky overrun flags.
module uart_receiver_sv
  import uart_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SYNC_FF = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [15:0]       comp,
  input  logic [1:0]        stop_sel,
  input  logic              rec_en,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              frame_err,
  output logic              overrun
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              w_rxs;
  rx_state_t         r_state;
  logic [15:0]       r_cnt;
  logic [15:0]       r_comp_l;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic              r_ferr;
  logic              r_rxs_d;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_err;
  logic              r_overrun;

  uart_sync_sv #(.SYNC_FF(SYNC_FF)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (uart_rx),
    .o_q    (w_rxs)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state     <= RX_IDLE;
      r_cnt       <= '0;
      r_comp_l    <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_ferr      <= 1'b0;
      r_rxs_d     <= 1'b1;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rxs_d <= w_rxs;

      if (r_rx_valid && rx_ack) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end

      if (r_state != RX_IDLE && !rec_en) begin
        r_state <= RX_IDLE;
      end else begin
        case (r_state)
          RX_IDLE: begin
            // edge (not level) trigger: a held-low line cannot restart a frame
            if (rec_en && comp >= 16'd2 && r_rxs_d && !w_rxs) begin
              r_comp_l <= comp;
              r_cnt    <= comp >> 1;
              r_state  <= RX_START;
            end
          end
          RX_START: begin
            if (r_cnt == 16'd0) begin
              if (w_rxs) begin
                r_state <= RX_IDLE;
              end else begin
                r_cnt     <= r_comp_l - 16'd1;
                r_bit_cnt <= '0;
                r_state   <= RX_DATA;
              end
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          RX_DATA: begin
            if (r_cnt == 16'd0) begin
              r_shreg   <= {w_rxs, r_shreg[DATA_W-1:1]};
              r_cnt     <= r_comp_l - 16'd1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == BW'(DATA_W - 1)) r_state <= RX_STOP1;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          RX_STOP1: begin
            if (r_cnt == 16'd0) begin
              r_ferr <= ~w_rxs;
              if (has_stop2(stop_sel)) begin
                r_cnt   <= r_comp_l - 16'd1;
                r_state <= RX_STOP2;
              end else begin
                r_state <= RX_DONE;
              end
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          RX_STOP2: begin
            if (r_cnt == 16'd0) begin
              r_ferr  <= r_ferr | ~w_rxs;
              r_state <= RX_DONE;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          RX_DONE: begin
            // an ack in this very cycle frees the slot for the new byte
            r_state <= RX_IDLE;
            if (!r_rx_valid || rx_ack) begin
              r_rx_data   <= r_shreg;
              r_frame_err <= r_ferr;
              r_rx_valid  <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
